regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-write-port register file for the MIPS integer and FPU datapaths; one module covers both integer and FPU register-file needs.
- Adds three things:
  - a second synchronous write port for long-latency FPU/load writeback;
  - optional write-to-read bypass;
  - a per-register pending scoreboard that hazard logic uses to stall reads of registers awaiting writeback.
- Two asynchronous read ports.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_BITS, 5, address width; depth = 2**ADDR_BITS.
- ZERO_REG, 1, 1 = register 0 is hard zero (integer file), 0 = register 0 is ordinary (FPU file).
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports.

Ports:
- Clk  in  1  clock, positive-edge.
- Reset  in  1  synchronous, active-high reset.
- ReadRegister1  in  ADDR_BITS  read port 1 address.
- ReadRegister2  in  ADDR_BITS  read port 2 address.
- ReadData1  out  WIDTH  read port 1 data.
- ReadData2  out  WIDTH  read port 2 data.
- ReadPending1  out  1  pending bit of ReadRegister1.
- ReadPending2  out  1  pending bit of ReadRegister2.
- WriteRegisterA  in  ADDR_BITS  port A (single-cycle ALU) write address.
- WriteDataA  in  WIDTH  port A write data.
- RegWriteA  in  1  port A write enable.
- WriteRegisterB  in  ADDR_BITS  port B (long-latency) write address.
- WriteDataB  in  WIDTH  port B write data.
- RegWriteB  in  1  port B write enable; also clears pending.
- IssueValid  in  1  marks IssueRegister pending.
- IssueRegister  in  ADDR_BITS  register whose result arrives later via port B.
- WriteConflict  out  1  registered; A and B wrote the same address last cycle.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset:
  - At a Clk edge with Reset=1: all registers go to 0, all pending bits go to 0, WriteConflict goes to 0.
  - Writes and issues presented in that cycle are discarded.
  - While Reset=1, bypass is disabled; read ports show stored contents.
- Reads:
  - Combinational from storage; zero-cycle latency.
  - With ZERO_REG=1, address 0 always reads 0 and pending 0, regardless of writes, issue or bypass.
- Writes:
  - Take effect at the Clk edge; data is visible through storage from the next cycle.
  - Port A and port B both write when their enables are high.
  - Same address on both ports: port A data is stored, and WriteConflict=1 for exactly the following cycle.
  - With ZERO_REG=1, writes and issues to address 0 are ignored and never raise WriteConflict.
- Bypass (BYPASS=1, Reset=0):
  - If RegWriteA and WriteRegisterA equals the read address, ReadData shows WriteDataA.
  - Otherwise, if RegWriteB and WriteRegisterB matches, ReadData shows WriteDataB.
  - Otherwise ReadData shows storage.
  - With BYPASS=0, a read returns the old value in the cycle of the write.
- Scoreboard (one bit per register):
  - Set at the edge when IssueValid=1 for IssueRegister.
  - Cleared at the edge when RegWriteB=1 for WriteRegisterB.
  - Set and clear on the same register in the same cycle: set wins, because the new issue supersedes.
  - Port A writes do not touch pending.
  - ReadPendingN is combinational from the pending bit.
  - With BYPASS=1, ReadPendingN reads 0 in the cycle that port B writes that register, unless the same cycle also issues to it.
  - Issuing to an already-pending register keeps it pending; no counting.
- Reset mid-operation: all pending bits are lost. An outstanding port B writeback arriving after reset writes data normally and clears an already-clear bit.
- Storage: behavioural array; no external register submodules.

Test Plan:
- Reset, then read all addresses -> every ReadData=0 and every ReadPending=0. Write 0xDEADBEEF to r5 via A, then assert Reset -> r5 reads 0 after the edge.
- ZERO_REG=1: write 0x12345678 to r0 via A and B with IssueValid on r0 -> r0 reads 0, pending 0, WriteConflict stays 0. With ZERO_REG=0 the same A write -> r0 reads 0x12345678.
- Same-cycle write to r7 via A=0xAAAA0000 and B=0x5555FFFF -> r7 stores 0xAAAA0000, WriteConflict=1 for one cycle then 0. Bypass in that cycle shows 0xAAAA0000.
- BYPASS=1: write r3=0x00000042 via B while reading r3 -> ReadData1=0x42 in the same cycle. BYPASS=0 -> shows the old value 0, then 0x42 next cycle.
- Issue r9, then wait 3 cycles -> ReadPending2=1 for r9. B writes r9=0xCAFEF00D -> pending reads 0 combinationally in the write cycle (BYPASS=1) and stays 0 after; data is 0xCAFEF00D.
- Issue r4 and B write r4 in the same cycle -> r4 holds the B data and pending remains 1. A write to a pending r4 -> data updates, pending stays 1.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-write-port register file with optional write-to-read bypass and a
// per-register pending scoreboard for long-latency writeback hazard tracking.
module regfile_mp #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    output logic                 ReadPending1,
    output logic                 ReadPending2,
    input  logic [ADDR_BITS-1:0] WriteRegisterA,
    input  logic [WIDTH-1:0]     WriteDataA,
    input  logic                 RegWriteA,
    input  logic [ADDR_BITS-1:0] WriteRegisterB,
    input  logic [WIDTH-1:0]     WriteDataB,
    input  logic                 RegWriteB,
    input  logic                 IssueValid,
    input  logic [ADDR_BITS-1:0] IssueRegister,
    output logic                 WriteConflict
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;

    logic writeA;
    logic writeB;
    logic issue;

    // Hard-zero register: drop every write and issue aimed at address 0.
    always_comb begin
        writeA = RegWriteA  && !(ZERO_REG != 0 && WriteRegisterA == '0);
        writeB = RegWriteB  && !(ZERO_REG != 0 && WriteRegisterB == '0);
        issue  = IssueValid && !(ZERO_REG != 0 && IssueRegister  == '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending       <= '0;
            WriteConflict <= 1'b0;
        end else begin
            // Port A is assigned last so it wins an address collision.
            if (writeB) regs[WriteRegisterB] <= WriteDataB;
            if (writeA) regs[WriteRegisterA] <= WriteDataA;
            // A fresh issue supersedes a completing writeback on the same register.
            if (writeB) pending[WriteRegisterB] <= 1'b0;
            if (issue)  pending[IssueRegister]  <= 1'b1;
            WriteConflict <= writeA && writeB && (WriteRegisterA == WriteRegisterB);
        end
    end

    logic bypassOn;
    assign bypassOn = (BYPASS != 0) && !Reset;

    always_comb begin
        ReadData1 = regs[ReadRegister1];
        if (bypassOn && writeA && WriteRegisterA == ReadRegister1) begin
            ReadData1 = WriteDataA;
        end else if (bypassOn && writeB && WriteRegisterB == ReadRegister1) begin
            ReadData1 = WriteDataB;
        end
        if (ZERO_REG != 0 && ReadRegister1 == '0) ReadData1 = '0;

        ReadData2 = regs[ReadRegister2];
        if (bypassOn && writeA && WriteRegisterA == ReadRegister2) begin
            ReadData2 = WriteDataA;
        end else if (bypassOn && writeB && WriteRegisterB == ReadRegister2) begin
            ReadData2 = WriteDataB;
        end
        if (ZERO_REG != 0 && ReadRegister2 == '0) ReadData2 = '0;
    end

    always_comb begin
        ReadPending1 = pending[ReadRegister1];
        if (bypassOn && writeB && WriteRegisterB == ReadRegister1 &&
            !(issue && IssueRegister == ReadRegister1)) begin
            ReadPending1 = 1'b0;
        end
        if (ZERO_REG != 0 && ReadRegister1 == '0) ReadPending1 = 1'b0;

        ReadPending2 = pending[ReadRegister2];
        if (bypassOn && writeB && WriteRegisterB == ReadRegister2 &&
            !(issue && IssueRegister == ReadRegister2)) begin
            ReadPending2 = 1'b0;
        end
        if (ZERO_REG != 0 && ReadRegister2 == '0) ReadPending2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance 0 is the integer flavour (hard zero, bypass),
// instance 1 the FPU flavour (ordinary r0, no bypass); both see the same stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  r1 = '0, r2 = '0;
    logic        wa = 1'b0, wb = 1'b0, iss = 1'b0;
    logic [4:0]  aAddr = '0, bAddr = '0, iAddr = '0;
    logic [31:0] aData = '0, bData = '0;

    logic [31:0] rdA [2];
    logic [31:0] rdB [2];
    logic        pdA [2];
    logic        pdB [2];
    logic        cf  [2];

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) u0 (
        .Clk(clk), .Reset(rst),
        .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rdA[0]), .ReadData2(rdB[0]),
        .ReadPending1(pdA[0]), .ReadPending2(pdB[0]),
        .WriteRegisterA(aAddr), .WriteDataA(aData), .RegWriteA(wa),
        .WriteRegisterB(bAddr), .WriteDataB(bData), .RegWriteB(wb),
        .IssueValid(iss), .IssueRegister(iAddr),
        .WriteConflict(cf[0])
    );

    regfile_mp #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(0)) u1 (
        .Clk(clk), .Reset(rst),
        .ReadRegister1(r1), .ReadRegister2(r2),
        .ReadData1(rdA[1]), .ReadData2(rdB[1]),
        .ReadPending1(pdA[1]), .ReadPending2(pdB[1]),
        .WriteRegisterA(aAddr), .WriteDataA(aData), .RegWriteA(wa),
        .WriteRegisterB(bAddr), .WriteDataB(bData), .RegWriteB(wb),
        .IssueValid(iss), .IssueRegister(iAddr),
        .WriteConflict(cf[1])
    );

    // Reference model: architectural register contents, pending set, conflict flag.
    logic [31:0] mm [2][32];
    bit   [31:0] pm [2];
    bit          cm [2];

    function automatic bit isZero(int k, logic [4:0] a);
        return (k == 0) && (a == 5'd0);
    endfunction

    function automatic logic [31:0] expData(int k, logic [4:0] a);
        bit byp = (k == 0) && !rst;
        if (isZero(k, a)) return 32'd0;
        if (byp && wa && aAddr == a) return aData;
        if (byp && wb && bAddr == a) return bData;
        return mm[k][a];
    endfunction

    function automatic logic expPend(int k, logic [4:0] a);
        bit byp = (k == 0) && !rst;
        if (isZero(k, a)) return 1'b0;
        if (byp && wb && bAddr == a && !(iss && iAddr == a)) return 1'b0;
        return pm[k][a];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) mm[k][i] = 32'd0;
                pm[k] = '0;
                cm[k] = 1'b0;
            end else begin
                bit okA, okB, okI;
                okA = wa  && !isZero(k, aAddr);
                okB = wb  && !isZero(k, bAddr);
                okI = iss && !isZero(k, iAddr);
                cm[k] = okA && okB && (aAddr == bAddr);
                if (okB) mm[k][bAddr] = bData;
                if (okA) mm[k][aAddr] = aData;
                if (okB) pm[k][bAddr] = 1'b0;
                if (okI) pm[k][iAddr] = 1'b1;
            end
        end
        if (rst) checking = 1'b1;
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d.data1", k), rdA[k], expData(k, r1));
                chk($sformatf("u%0d.data2", k), rdB[k], expData(k, r2));
                chk($sformatf("u%0d.pend1", k), {31'd0, pdA[k]}, {31'd0, expPend(k, r1)});
                chk($sformatf("u%0d.pend2", k), {31'd0, pdB[k]}, {31'd0, expPend(k, r2)});
                chk($sformatf("u%0d.conflict", k), {31'd0, cf[k]}, {31'd0, cm[k]});
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
        wa = 1'b0; wb = 1'b0; iss = 1'b0; rst = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset, then sweep every address on both read ports.
        go(); rst = 1'b1;
        go(); r1 = 5'd0; r2 = 5'd31;
        settle();
        chk("lit.resetData", rdB[0], 32'd0);
        for (int i = 0; i < 32; i++) begin
            go(); r1 = 5'(i); r2 = 5'(31 - i);
            settle();
        end

        // Reset discards stored data.
        go(); wa = 1'b1; aAddr = 5'd5; aData = 32'hDEADBEEF;
        go(); rst = 1'b1; r1 = 5'd5;
        settle();
        chk("lit.r5BeforeReset", rdA[0], 32'hDEADBEEF);
        go(); r1 = 5'd5;
        settle();
        chk("lit.r5AfterReset", rdA[1], 32'd0);

        // r0 write/issue on both ports.
        go(); r1 = 5'd0;
        wa = 1'b1; aAddr = 5'd0; aData = 32'h12345678;
        wb = 1'b1; bAddr = 5'd0; bData = 32'h12345678;
        iss = 1'b1; iAddr = 5'd0;
        settle();
        chk("lit.r0Bypass", rdA[0], 32'd0);
        go(); r1 = 5'd0;
        settle();
        chk("lit.r0Zero", rdA[0], 32'd0);
        chk("lit.r0NoConflict", {31'd0, cf[0]}, 32'd0);
        chk("lit.r0Fpu", rdA[1], 32'h12345678);
        chk("lit.r0FpuPend", {31'd0, pdA[1]}, 32'd1);

        // Collision on r7.
        go(); r1 = 5'd7;
        wa = 1'b1; aAddr = 5'd7; aData = 32'hAAAA0000;
        wb = 1'b1; bAddr = 5'd7; bData = 32'h5555FFFF;
        settle();
        chk("lit.r7Bypass", rdA[0], 32'hAAAA0000);
        go(); r1 = 5'd7;
        settle();
        chk("lit.r7Stored", rdA[0], 32'hAAAA0000);
        chk("lit.r7Conflict", {31'd0, cf[0]}, 32'd1);
        go();
        settle();
        chk("lit.r7ConflictGone", {31'd0, cf[0]}, 32'd0);

        // B write to r3 while reading it.
        go(); r1 = 5'd3; wb = 1'b1; bAddr = 5'd3; bData = 32'h00000042;
        settle();
        chk("lit.r3Bypass", rdA[0], 32'h42);
        chk("lit.r3NoBypass", rdA[1], 32'd0);
        go(); r1 = 5'd3;
        settle();
        chk("lit.r3Next", rdA[1], 32'h42);

        // Scoreboard on r9.
        go(); iss = 1'b1; iAddr = 5'd9; r2 = 5'd9;
        go(); go(); go();
        settle();
        chk("lit.r9Pending", {31'd0, pdB[0]}, 32'd1);
        go(); wb = 1'b1; bAddr = 5'd9; bData = 32'hCAFEF00D; r2 = 5'd9;
        settle();
        chk("lit.r9PendBypass", {31'd0, pdB[0]}, 32'd0);
        chk("lit.r9PendNoBypass", {31'd0, pdB[1]}, 32'd1);
        go(); r2 = 5'd9;
        settle();
        chk("lit.r9Data", rdB[0], 32'hCAFEF00D);
        chk("lit.r9Cleared", {31'd0, pdB[1]}, 32'd0);

        // Issue and B write on r4 together, then A write while pending.
        go(); r1 = 5'd4; iss = 1'b1; iAddr = 5'd4;
        wb = 1'b1; bAddr = 5'd4; bData = 32'h11112222;
        go(); r1 = 5'd4;
        settle();
        chk("lit.r4Data", rdA[0], 32'h11112222);
        chk("lit.r4Pending", {31'd0, pdA[0]}, 32'd1);
        go(); r1 = 5'd4; wa = 1'b1; aAddr = 5'd4; aData = 32'h33334444;
        go(); r1 = 5'd4;
        settle();
        chk("lit.r4AData", rdA[1], 32'h33334444);
        chk("lit.r4StillPending", {31'd0, pdA[1]}, 32'd1);

        // Reset with an outstanding issue, then the late writeback.
        go(); iss = 1'b1; iAddr = 5'd10; r2 = 5'd10;
        go(); rst = 1'b1;
        go(); wb = 1'b1; bAddr = 5'd10; bData = 32'h00000077;
        go(); r2 = 5'd10;
        settle();
        chk("lit.r10Data", rdB[1], 32'h77);
        chk("lit.r10Pend", {31'd0, pdB[1]}, 32'd0);

        // Mixed traffic on both ports.
        for (int i = 0; i < 24; i++) begin
            go();
            r1 = 5'(i * 7); r2 = 5'(i * 3 + 1);
            wa = i[0]; aAddr = 5'(i * 5); aData = 32'h1000_0000 + 32'(i);
            wb = i[1]; bAddr = 5'(i * 5 + i[2]); bData = 32'h2000_0000 + 32'(i);
            iss = (i % 3 == 0); iAddr = 5'(i * 7);
            settle();
        end
        go();
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
